pdu_ctrl: RTL

PDU_CTRL -- requirements
Module: pdu_ctrl

---
 rtl/pdu_ctrl_if.sv | 22 ++
 rtl/pdu_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pdu_ctrl_if.sv
// Register-dump stream between the debug controller and its consumer.
// The controller drives valid/addr/data and the consumer returns ready.
interface pdu_ctrl_if;
   logic        dump_valid;
   logic        dump_ready;
   logic [7:0]  dump_addr;
   logic [31:0] dump_data;

   modport master (
      output dump_valid,
      output dump_addr,
      output dump_data,
      input  dump_ready
   );

   modport slave (
      input  dump_valid,
      input  dump_addr,
      input  dump_data,
      output dump_ready
   );
endinterface

// File: rtl/pdu_ctrl.sv
// Debug controller: free-run, single-step and breakpoint gating of a CPU,
// followed by a register-file dump. Breakpoints exist only with PDU_BREAKPOINT_EN defined.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | CPU halted, waiting for run level or step edge
//   RUN     | CPU free-running until run drops or breakpoint
//   STEP    | exactly one enabled CPU cycle
//   DUMP    | walk register file 0..DUMP_LAST over the stream
module pdu_ctrl #(
   parameter int unsigned DUMP_LAST = 31
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        run,
   input  logic        step,
   input  logic        bp_en,
   input  logic [31:0] bp_addr,
   input  logic [31:0] debug_pc,
   input  logic [31:0] debug_rf_data,
   output logic        cpu_en,
   output logic [7:0]  debug_dm_rf_addr,
   output logic        halted,
   output logic [31:0] halt_pc,
   output logic [31:0] instr_cnt,
   pdu_ctrl_if.master  dump
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STEP, ST_DUMP} state_t;

   localparam logic [7:0] LAST_IDX = 8'(DUMP_LAST);

   state_t      state_q, state_d;
   logic        step_prev_q, step_prev_d;
   logic [7:0]  idx_q, idx_d;
   logic        dump_valid_q, dump_valid_d;
   logic [7:0]  dump_addr_q, dump_addr_d;
   logic [31:0] dump_data_q, dump_data_d;
   logic [31:0] halt_pc_q, halt_pc_d;
   logic [31:0] instr_cnt_q, instr_cnt_d;
   logic        bp_hit;
   logic        step_rise;

`ifdef PDU_BREAKPOINT_EN
   // bp_skip lets a resume from the breakpoint PC commit that instruction once
   logic bp_skip_q, bp_skip_d;

   assign bp_hit = bp_en && (debug_pc == bp_addr) && !bp_skip_q;

   always_comb begin
      bp_skip_d = bp_skip_q;
      if (state_q == ST_IDLE && run) begin
         bp_skip_d = 1'b1;
      end else if (state_q == ST_RUN) begin
         bp_skip_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) bp_skip_q <= 1'b0;
      else       bp_skip_q <= bp_skip_d;
   end
`else
   logic unused_bp;
   assign unused_bp = ^{bp_en, bp_addr};
   assign bp_hit    = 1'b0;
`endif

   assign step_rise        = step && !step_prev_q;
   assign cpu_en           = (state_q == ST_RUN && !bp_hit) || (state_q == ST_STEP);
   assign halted           = (state_q == ST_IDLE);
   assign debug_dm_rf_addr = idx_q;
   assign halt_pc          = halt_pc_q;
   assign instr_cnt        = instr_cnt_q;
   assign dump.dump_valid  = dump_valid_q;
   assign dump.dump_addr   = dump_addr_q;
   assign dump.dump_data   = dump_data_q;

   always_comb begin
      state_d      = state_q;
      step_prev_d  = step;
      idx_d        = idx_q;
      dump_valid_d = dump_valid_q;
      dump_addr_d  = dump_addr_q;
      dump_data_d  = dump_data_q;
      halt_pc_d    = halt_pc_q;
      instr_cnt_d  = cpu_en ? instr_cnt_q + 32'd1 : instr_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (run)            state_d = ST_RUN;
            else if (step_rise) state_d = ST_STEP;
         end
         ST_RUN: begin
            if (bp_hit || !run) begin
               state_d = ST_DUMP;
               if (!cpu_en) halt_pc_d = debug_pc;
            end
         end
         ST_STEP: state_d = ST_DUMP;
         ST_DUMP: begin
            if (!dump_valid_q) begin
               dump_data_d  = debug_rf_data;
               dump_addr_d  = idx_q;
               dump_valid_d = 1'b1;
               // CPU is frozen in DUMP, so the first cycle's PC is the first uncommitted one
               if (idx_q == 8'd0) halt_pc_d = debug_pc;
            end else if (dump.dump_ready) begin
               dump_valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  idx_d   = 8'd0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         step_prev_q  <= 1'b0;
         idx_q        <= 8'd0;
         dump_valid_q <= 1'b0;
         dump_addr_q  <= 8'd0;
         dump_data_q  <= 32'd0;
         halt_pc_q    <= 32'd0;
         instr_cnt_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         step_prev_q  <= step_prev_d;
         idx_q        <= idx_d;
         dump_valid_q <= dump_valid_d;
         dump_addr_q  <= dump_addr_d;
         dump_data_q  <= dump_data_d;
         halt_pc_q    <= halt_pc_d;
         instr_cnt_q  <= instr_cnt_d;
      end
   end

endmodule
